hdr_route_stage: RTL
====================

// Module: hdr_route_stage
// PURPOSE
//  Registered header-decode + route-compute stage for the Cardinal router input path.
//  Accepts one packet per cycle over valid/ready and splits the header into fields.
//  Computes the output port (XY dimension-order) and decrements the active hop count.
//  A 2-entry skid FIFO drives the updated packet and one-hot route to the switch allocator.
// PARAMETERS
//  PKT_W   64  total packet width; header is packed at the MSB end, payload fills the rest
//  RSV_W   5   reserved-field width, passed through unchanged
//  HOP_W   4   width of each of Hx and Hy; unsigned binary hop count
//  SRC_W   8   width of each of SrcX and SrcY
//  CNT_W   16  width of the forwarded-packet counter
//  Header layout, MSB first: vc(1) dx(1) dy(1) rsv(RSV_W) hx(HOP_W) hy(HOP_W) srcx(SRC_W) srcy(SRC_W) payload
// PORTS
//  clk        in   1      clock; all state updates on posedge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      upstream packet valid
//  in_ready   out  1      stage can accept a packet (FIFO count<2 and reset low)
//  in_pkt     in   PKT_W  incoming packet
//  out_valid  out  1      head FIFO entry valid
//  out_ready  in   1      downstream accepts the head entry
//  out_pkt    out  PKT_W  packet with updated hop field
//  out_route  out  5      one-hot port: [0]=E [1]=W [2]=N [3]=S [4]=LOCAL
//  out_vc     out  1      vc bit of the head packet
//  fwd_cnt    out  CNT_W  saturating count of output handshakes
// BEHAVIOUR
//  Reset: FIFO count=0, out_valid=0, out_pkt=0, out_route=0, out_vc=0, fwd_cnt=0.
//  in_ready=0 while reset is high. Reset mid-operation drops both stored entries.
//  Push = in_valid&in_ready. Pop = out_valid&out_ready.
//  Route computed combinationally on in_pkt and stored with the packet at push:
//   hx!=0 -> X hop: route=dx?W:E, hx'=hx-1, hy unchanged
//   hx==0, hy!=0 -> Y hop: route=dy?S:N, hy'=hy-1
//   hx==0, hy==0 -> LOCAL, header unchanged
//  All fields other than hx/hy pass bit-exact: vc, dx, dy, rsv, src, payload.
//  Hop decrement never wraps; zero selects the next dimension or LOCAL.
//  Latency: a push into an empty FIFO gives out_valid=1 on the next cycle. No combinational path in->out.
//  in_ready depends only on registered count; it does not look at out_ready.
//  Push and pop in the same cycle: count unchanged. Head advances; the new entry goes to the tail. Order is preserved.
//  count==2 -> in_ready=0; a pop that cycle frees a slot, and in_ready=1 on the next cycle.
//  count==0 -> out_valid=0, and out_pkt/out_route hold their last values.
//  out_* stay stable while out_valid=1 and out_ready=0.
//  fwd_cnt increments on each pop and saturates at 2^CNT_W-1 (no wrap).
// TESTING
//  1: in_pkt={1,0,0,5'b01010,4'd3,4'd3,8'h01,8'h01,32'hDEADBEEF}, out_ready=1
//     -> next cycle out_route=E (5'b00001), hx=2, hy=3, all other fields bit-exact, out_vc=1.
//  2: hx=0, hy=2, dy=1 -> route=S (5'b01000), hy=1.
//     hx=0, hy=0 -> route=LOCAL (5'b10000), packet unchanged.
//  3: hold out_ready=0 and push 3 packets back-to-back
//     -> in_ready=0 after the 2nd push, 3rd not accepted, out_* stable.
//     Release -> packets drain in order, 2 pops.
//  4: count=1, push and pop in the same cycle for 10 cycles
//     -> count stays 1, in_ready=1 throughout, output order matches input order.
//  5: assert reset with 2 entries stored
//     -> next cycle out_valid=0, fwd_cnt=0; in_ready=1 the cycle after reset deasserts.
//  6: CNT_W=4, run 20 pops -> fwd_cnt saturates at 15.
//     Random valid/ready traffic checked against a reference model gives zero mismatches.

Source files
------------

// File: rtl/hdr_route_stage.sv
// hdr_route_stage: header decode and XY route compute for the router input path.
// The route and hop-decremented header are computed combinationally from in_pkt
// and stored with the packet in a 2-entry skid FIFO (head register + skid register).
// The head register drives out_* directly, so no input reaches an output combinationally.
module hdr_route_stage #(
  parameter int PKT_W = 64,
  parameter int RSV_W = 5,
  parameter int HOP_W = 4,
  parameter int SRC_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PKT_W-1:0] in_pkt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PKT_W-1:0] out_pkt,
  output logic [4:0]       out_route,
  output logic             out_vc,
  output logic [CNT_W-1:0] fwd_cnt
);

  // Header bit positions, MSB first: vc dx dy rsv hx hy srcx srcy payload
  localparam int VC_BIT = PKT_W - 1;
  localparam int DX_BIT = PKT_W - 2;
  localparam int DY_BIT = PKT_W - 3;
  localparam int HX_LSB = PKT_W - 3 - RSV_W - HOP_W;
  localparam int HY_LSB = HX_LSB - HOP_W;
  // Source fields sit directly below hy; they pass through untouched.
  localparam int SRC_LSB = HY_LSB - 2 * SRC_W;

  localparam logic [4:0] ROUTE_E     = 5'b00001;
  localparam logic [4:0] ROUTE_W     = 5'b00010;
  localparam logic [4:0] ROUTE_N     = 5'b00100;
  localparam logic [4:0] ROUTE_S     = 5'b01000;
  localparam logic [4:0] ROUTE_LOCAL = 5'b10000;

  // Hop decrement that parks at zero instead of wrapping.
  function automatic logic [HOP_W-1:0] hop_dec(input logic [HOP_W-1:0] h);
    if (h == '0) return '0;
    return h - HOP_W'(1);
  endfunction

  // Forwarded-packet counter increment that saturates at all-ones.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    if (c == '1) return c;
    return c + CNT_W'(1);
  endfunction

  // ---- stage p0: decode and route compute on the incoming packet ----
  logic [HOP_W-1:0] hx_p0;
  logic [HOP_W-1:0] hy_p0;
  logic             dx_p0;
  logic             dy_p0;
  logic [PKT_W-1:0] pkt_p0;
  logic [4:0]       route_p0;

  assign hx_p0 = in_pkt[HX_LSB +: HOP_W];
  assign hy_p0 = in_pkt[HY_LSB +: HOP_W];
  assign dx_p0 = in_pkt[DX_BIT];
  assign dy_p0 = in_pkt[DY_BIT];

  // X dimension first, then Y, then deliver locally; only the active hop field changes.
  always_comb begin
    pkt_p0   = in_pkt;
    route_p0 = ROUTE_LOCAL;
    if (hx_p0 != '0) begin
      route_p0                   = dx_p0 ? ROUTE_W : ROUTE_E;
      pkt_p0[HX_LSB +: HOP_W]    = hop_dec(hx_p0);
    end else if (hy_p0 != '0) begin
      route_p0                   = dy_p0 ? ROUTE_S : ROUTE_N;
      pkt_p0[HY_LSB +: HOP_W]    = hop_dec(hy_p0);
    end
  end

  // ---- stage p1: 2-entry skid FIFO (head drives outputs, skid holds the second entry) ----
  logic [PKT_W-1:0] head_pkt_q,   head_pkt_d;
  logic [4:0]       head_route_q, head_route_d;
  logic             head_vld_q,   head_vld_d;
  logic [PKT_W-1:0] skid_pkt_q,   skid_pkt_d;
  logic [4:0]       skid_route_q, skid_route_d;
  logic             skid_vld_q,   skid_vld_d;
  logic [CNT_W-1:0] fwd_cnt_q,    fwd_cnt_d;
  logic             push;
  logic             pop;

  // The skid entry is only ever occupied behind a valid head, so "full" is skid_vld_q.
  assign in_ready = ~reset & ~(head_vld_q & skid_vld_q);
  assign push     = in_valid & in_ready;
  assign pop      = head_vld_q & out_ready;

  // FIFO next state: pop promotes skid to head, push fills the first free slot in order.
  always_comb begin
    head_pkt_d   = head_pkt_q;
    head_route_d = head_route_q;
    head_vld_d   = head_vld_q;
    skid_pkt_d   = skid_pkt_q;
    skid_route_d = skid_route_q;
    skid_vld_d   = skid_vld_q;
    fwd_cnt_d    = fwd_cnt_q;
    if (pop) begin
      fwd_cnt_d = cnt_sat_inc(fwd_cnt_q);
      if (skid_vld_q) begin
        head_pkt_d   = skid_pkt_q;
        head_route_d = skid_route_q;
        if (push) begin
          skid_pkt_d   = pkt_p0;
          skid_route_d = route_p0;
        end else begin
          skid_vld_d   = 1'b0;
        end
      end else if (push) begin
        head_pkt_d   = pkt_p0;
        head_route_d = route_p0;
      end else begin
        // Going empty: head payload is left in place so out_pkt/out_route hold.
        head_vld_d   = 1'b0;
      end
    end else if (push) begin
      if (!head_vld_q) begin
        head_pkt_d   = pkt_p0;
        head_route_d = route_p0;
        head_vld_d   = 1'b1;
      end else begin
        skid_pkt_d   = pkt_p0;
        skid_route_d = route_p0;
        skid_vld_d   = 1'b1;
      end
    end
  end

  // Head register, occupancy and counter; reset clears everything visible at the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_pkt_q   <= '0;
      head_route_q <= '0;
      head_vld_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      fwd_cnt_q    <= '0;
    end else begin
      head_pkt_q   <= head_pkt_d;
      head_route_q <= head_route_d;
      head_vld_q   <= head_vld_d;
      skid_vld_q   <= skid_vld_d;
      fwd_cnt_q    <= fwd_cnt_d;
    end
  end

  // Skid data is qualified by skid_vld_q, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_pkt_q   <= skid_pkt_d;
    skid_route_q <= skid_route_d;
  end

  // ---- outputs: straight from the head register ----
  assign out_valid = head_vld_q;
  assign out_pkt   = head_pkt_q;
  assign out_route = head_route_q;
  assign out_vc    = head_pkt_q[VC_BIT];
  assign fwd_cnt   = fwd_cnt_q;

  // The source fields are forwarded as part of the packet; named here for readers only.
  logic [2*SRC_W-1:0] src_unused;
  assign src_unused = head_pkt_q[SRC_LSB +: 2*SRC_W];

endmodule
